ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
- AHB-Lite slave to APB master bridge. Sits directly upstream of apb_slave and drives its psel/penable/paddr/pwrite/pwdata, consuming prdata/pready.
- One outstanding transfer at a time. AHB wait states are inserted via hreadyout until the APB access completes.
- AHB and APB share one clock (pclk) and one reset (rst_n).

Parameters:
- addrWidth, 32, address width on both the AHB and APB sides.
- dataWidth, 32, data width on both sides. Must be 32 when strobes are enabled.

Ports:
- pclk  in  1  single clock for both the AHB and APB sides.
- rst_n  in  1  asynchronous, active-low reset.
- hsel  in  1  AHB slave select.
- haddr  in  addrWidth  AHB address.
- htrans  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hwrite  in  1  AHB write flag.
- hsize  in  3  AHB transfer size.
- hwdata  in  dataWidth  AHB write data, valid in the data phase.
- hready_in  in  1  AHB bus ready; address phase is valid only when high.
- hreadyout  out  1  this slave's ready.
- hresp  out  1  AHB response; always OKAY (0).
- hrdata  out  dataWidth  AHB read data.
- paddr  out  addrWidth  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  dataWidth  APB write data.
- prdata  in  dataWidth  APB read data.
- pready  in  1  APB ready.

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, paddr=0, pwrite=0, psel=0, penable=0, pwdata=0. State=IDLE.
- All outputs are registered. hresp is tied to 0.
- Transfer accept condition: hsel && hready_in && htrans[1] while in IDLE. BUSY and IDLE transfers are ignored, and hreadyout stays 1.
- On accept: latch haddr into paddr, hwrite into pwrite, hsize internally; drive hreadyout<=0.
  - Read: next state SETUP, psel<=1.
  - Write: next state WCAP.
- WCAP (1 cycle, first write data phase): pwdata<=hwdata, psel<=1, then SETUP.
- SETUP (1 cycle): psel=1, penable=0; then ACCESS with penable<=1.
- ACCESS: hold psel=1, penable=1, and keep paddr/pwrite/pwdata stable until pready is sampled 1. On that edge:
  - psel<=0, penable<=0, hreadyout<=1, state IDLE.
  - Read only: hrdata<=prdata.
- ACCESS has no timeout; an indefinite pready=0 stalls AHB indefinitely.
- Pipelining: the cycle in which hreadyout returns to 1 is IDLE. A new address phase presented in that cycle is accepted (back-to-back). No idle cycle is required between transfers.
- hrdata holds its last read value until the next completed read; writes do not modify it.
- Latency against apb_slave (pready one cycle into ACCESS, seen on the second ACCESS cycle):
  - Read: 3 AHB wait states.
  - Write: 4 AHB wait states.
- hsize > 3'b010 is performed as a word transfer; no ERROR response.
- paddr is haddr passed through unmodified. Address mapping is decided by the APB slave.
- Reset asserted mid-transfer: all outputs go to reset values immediately (async), psel drops, and the transfer is lost.

Optional Feature:
- Macro: AHB_APB_PSTRB_EN.
- Defined:
  - Adds output pstrb[3:0], registered alongside paddr at accept.
  - Decode: byte: 4'b0001<<haddr[1:0]; halfword: haddr[1]?4'b1100:4'b0011; word: 4'b1111.
  - Reads drive pstrb=0.
  - Resets to 0.
- Undefined: no pstrb port; behaviour otherwise identical.

Decomposition:
- Package ahb_apb_pkg:
  - htrans encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY.
  - hsize codes (SIZE_BYTE/HALF/WORD).
  - FSM state encoding IDLE/WCAP/SETUP/ACCESS (2 bits).
- Sub-module apb_strb_gen: combinational hsize/haddr[1:0] to strobe decode. Instantiated only under AHB_APB_PSTRB_EN.
- Everything else stays in one module.

Test Plan:
- Reset → hreadyout=1, psel=0, penable=0, hrdata=0. Assert rst_n=0 during ACCESS → psel/penable drop immediately, hreadyout=1.
- NONSEQ write haddr=0x10, hwdata=0xDEADBEEF → one WCAP cycle, then SETUP with pwdata=0xDEADBEEF, paddr=0x10; ACCESS held until pready; hreadyout low for exactly 4 cycles. Then read 0x10 → hrdata=0xDEADBEEF after 3 wait states.
- Back-to-back write 0x20=0x11111111 then read 0x20 presented on the completion cycle → no idle cycle on APB between transfers; hrdata=0x11111111.
- htrans=BUSY or IDLE with hsel=1, or hsel=1 with hready_in=0 → no psel assertion; hreadyout stays 1.
- Slave model holding pready=0 for 5 cycles → penable, paddr and pwdata stable throughout; hreadyout=0 until the cycle after pready=1.
- With AHB_APB_PSTRB_EN defined:
  - byte write at haddr=0x03 → pstrb=4'b1000.
  - halfword write at haddr=0x02 → pstrb=4'b1100.
  - word write → 4'b1111.
  - read → pstrb=4'b0000.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge: AHB transfer types, response,
// transfer sizes and the bridge FSM state.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY = 1'b0;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WCAP   = 2'd1,
        SETUP  = 2'd2,
        ACCESS = 2'd3
    } state_e;

endpackage

// File: rtl/apb_strb_gen.sv
// Byte-lane strobe decode from AHB transfer size and the low address bits.
// Sizes larger than a word are treated as a full word.
module apb_strb_gen
    import ahb_apb_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_strb
);

    always_comb begin
        case (i_hsize)
            SIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
            SIZE_HALF: o_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   o_strb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge, one outstanding transfer, all outputs registered.
// Define AHB_APB_PSTRB_EN to add the pstrb output driven by apb_strb_gen.
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 hsel,
    input  logic [addrWidth-1:0] haddr,
    input  logic [1:0]           htrans,
    input  logic                 hwrite,
    input  logic [2:0]           hsize,
    input  logic [dataWidth-1:0] hwdata,
    input  logic                 hready_in,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic [dataWidth-1:0] hrdata,
    output logic [addrWidth-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 penable,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready
`ifdef AHB_APB_PSTRB_EN
    ,
    output logic [3:0]           pstrb
`endif
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_hreadyout, w_hreadyout_nxt;
    logic [dataWidth-1:0] r_hrdata,    w_hrdata_nxt;
    logic [addrWidth-1:0] r_paddr,     w_paddr_nxt;
    logic                 r_pwrite,    w_pwrite_nxt;
    logic                 r_psel,      w_psel_nxt;
    logic                 r_penable,   w_penable_nxt;
    logic [dataWidth-1:0] r_pwdata,    w_pwdata_nxt;
    logic [2:0]           r_hsize,     w_hsize_nxt;
    logic                 w_accept;
    logic                 w_unused;

    // Only NONSEQ/SEQ start a transfer; BUSY and IDLE are transparent.
    assign w_accept = hsel && hready_in && htrans[1];

    // The latched size is informational only; fold it into a sink.
    assign w_unused = ^{htrans[0], r_hsize};

`ifdef AHB_APB_PSTRB_EN
    logic [3:0] r_pstrb, w_pstrb_nxt;
    logic [3:0] w_strb;

    apb_strb_gen u_strb_gen (
        .i_hsize   (hsize),
        .i_addr_lo (haddr[1:0]),
        .o_strb    (w_strb)
    );

    always_comb begin
        w_pstrb_nxt = r_pstrb;
        if (r_state == IDLE && w_accept) begin
            w_pstrb_nxt = hwrite ? w_strb : 4'b0000;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pstrb <= 4'b0000;
        end else begin
            r_pstrb <= w_pstrb_nxt;
        end
    end

    assign pstrb = r_pstrb;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = hwrite ? WCAP : SETUP;
            WCAP:    w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (pready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_hreadyout_nxt = r_hreadyout;
        w_hrdata_nxt    = r_hrdata;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwdata_nxt    = r_pwdata;
        w_hsize_nxt     = r_hsize;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_paddr_nxt     = haddr;
                    w_pwrite_nxt    = hwrite;
                    w_hsize_nxt     = hsize;
                    w_hreadyout_nxt = 1'b0;
                    // Writes wait one cycle in WCAP for hwdata before selecting.
                    w_psel_nxt      = !hwrite;
                end
            end
            WCAP: begin
                w_pwdata_nxt = hwdata;
                w_psel_nxt   = 1'b1;
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_hreadyout_nxt = 1'b1;
                    if (!r_pwrite) w_hrdata_nxt = prdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hreadyout <= 1'b1;
            r_hrdata    <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwdata    <= '0;
            r_hsize     <= 3'b000;
        end else begin
            r_hreadyout <= w_hreadyout_nxt;
            r_hrdata    <= w_hrdata_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_hsize     <= w_hsize_nxt;
        end
    end

    assign hreadyout = r_hreadyout;
    assign hresp     = HRESP_OKAY;
    assign hrdata    = r_hrdata;
    assign paddr     = r_paddr;
    assign pwrite    = r_pwrite;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: directed vector table, ignored-transfer and reset sequences,
// then random transfers against a memory/latency reference model and an APB slave model.
module tb_ahb_apb_bridge;
    import ahb_apb_pkg::*;

    logic        pclk, rst_n;
    logic        hsel, hwrite, hready_in, hreadyout, hresp;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, hrdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready;
`ifdef AHB_APB_PSTRB_EN
    logic [3:0]  pstrb;
`endif

    ahb_apb_bridge #(.addrWidth(32), .dataWidth(32)) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready_in (hready_in),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
`ifdef AHB_APB_PSTRB_EN
        ,
        .pstrb     (pstrb)
`endif
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Expectations the APB slave model checks while psel is high
    logic [31:0] g_exp_addr  = '0;
    logic [31:0] g_exp_wdata = '0;
    logic        g_exp_write = 1'b0;
    logic [3:0]  g_exp_strb  = '0;
    int          g_wait      = 1;
    int          slave_acc   = 0;

    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] last_rd = '0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        int          wait_n;
        bit          b2b;
        int          exp_waits;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] strb_rule(input bit wr, input logic [31:0] a, input logic [2:0] sz);
        logic [3:0] one;
        one = 4'b0001;
        if (!wr) return 4'b0000;
        if (sz == 3'd0) return one << a[1:0];
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // APB slave: pready rises on ACCESS cycle number g_wait+1
    initial begin
        pready = 1'b0;
        prdata = '0;
        forever begin
            @(negedge pclk);
            if (psel && rst_n) begin
                chk("apb_paddr", paddr, g_exp_addr);
                chk("apb_pwrite", {31'b0, pwrite}, {31'b0, g_exp_write});
                if (g_exp_write) chk("apb_pwdata", pwdata, g_exp_wdata);
`ifdef AHB_APB_PSTRB_EN
                chk("apb_pstrb", {28'b0, pstrb}, {28'b0, g_exp_strb});
`endif
                if (penable) begin
                    slave_acc++;
                    if (slave_acc == g_wait + 1) begin
                        pready = 1'b1;
                        if (pwrite) slave_mem[paddr] = pwdata;
                        else prdata = slave_mem.exists(paddr) ? slave_mem[paddr] : ~paddr;
                    end else begin
                        pready = 1'b0;
                    end
                end else begin
                    slave_acc = 0;
                    pready    = 1'b0;
                end
            end else begin
                slave_acc = 0;
                pready    = 1'b0;
            end
        end
    end

    // Starts at a negedge with hreadyout high; returns at the completion negedge.
    task automatic ahb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] size, input logic [1:0] trans,
                            output int waits, output logic [31:0] rdata);
        hsel      = 1'b1;
        htrans    = trans;
        haddr     = addr;
        hwrite    = wr;
        hsize     = size;
        hready_in = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwdata = wr ? wdata : $urandom;
        waits  = 0;
        while (hreadyout == 1'b0 && waits < 200) begin
            waits++;
            hready_in = 1'b0;
            @(negedge pclk);
        end
        hready_in = 1'b1;
        rdata     = hrdata;
    endtask

    task automatic run_xfer(input string tag, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] size, input logic [1:0] trans,
                            input int wait_n, input bit b2b, input int exp_waits,
                            input logic [31:0] exp_rdata, input logic [3:0] exp_strb);
        int          waits;
        logic [31:0] rd;
        if (!b2b) @(negedge pclk);
        g_exp_addr  = addr;
        g_exp_write = wr;
        g_exp_wdata = wdata;
        g_exp_strb  = exp_strb;
        g_wait      = wait_n;
        ahb_xfer(wr, addr, wdata, size, trans, waits, rd);
        chk($sformatf("%s_waits", tag), waits, exp_waits);
        chk($sformatf("%s_hrdata", tag), rd, exp_rdata);
        chk($sformatf("%s_hresp", tag), {31'b0, hresp}, {31'b0, HRESP_OKAY});
        $display("[TB] %s %s addr=0x%h wdata=0x%h size=%0d wait=%0d b2b=%0d waits=%0d hrdata=0x%h",
                 tag, wr ? "WR" : "RD", addr, wdata, size, wait_n, b2b, waits, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ign_trans [4];
        logic        ign_hsel  [4];
        logic        ign_rdy   [4];
        int          cnt;

        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1, 1'b0, 4, 32'h00000000, 4'hF};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        SIZE_WORD, 1, 1'b0, 3, 32'hDEADBEEF, 4'h0};
        vecs[2]  = '{1'b1, 32'h20, 32'h11111111, SIZE_WORD, 1, 1'b0, 4, 32'hDEADBEEF, 4'hF};
        vecs[3]  = '{1'b0, 32'h20, 32'h0,        SIZE_WORD, 1, 1'b1, 3, 32'h11111111, 4'h0};
        vecs[4]  = '{1'b1, 32'h30, 32'hCAFEF00D, SIZE_WORD, 5, 1'b0, 8, 32'h11111111, 4'hF};
        vecs[5]  = '{1'b0, 32'h30, 32'h0,        SIZE_WORD, 5, 1'b1, 7, 32'hCAFEF00D, 4'h0};
        vecs[6]  = '{1'b1, 32'h03, 32'h000000AA, SIZE_BYTE, 1, 1'b0, 4, 32'hCAFEF00D, 4'h8};
        vecs[7]  = '{1'b1, 32'h02, 32'h0000BBBB, SIZE_HALF, 1, 1'b0, 4, 32'hCAFEF00D, 4'hC};
        vecs[8]  = '{1'b1, 32'h40, 32'h12345678, 3'b011,    1, 1'b1, 4, 32'hCAFEF00D, 4'hF};
        vecs[9]  = '{1'b0, 32'h40, 32'h0,        3'b111,    0, 1'b0, 2, 32'h12345678, 4'h0};
        vecs[10] = '{1'b0, 32'h50, 32'h0,        SIZE_WORD, 2, 1'b0, 4, 32'hFFFFFFAF, 4'h0};
        vecs[11] = '{1'b1, 32'h50, 32'h00000000, SIZE_WORD, 0, 1'b1, 3, 32'hFFFFFFAF, 4'hF};

        ign_trans[0] = HTRANS_BUSY;   ign_hsel[0] = 1'b1; ign_rdy[0] = 1'b1;
        ign_trans[1] = HTRANS_IDLE;   ign_hsel[1] = 1'b1; ign_rdy[1] = 1'b1;
        ign_trans[2] = HTRANS_NONSEQ; ign_hsel[2] = 1'b1; ign_rdy[2] = 1'b0;
        ign_trans[3] = HTRANS_NONSEQ; ign_hsel[3] = 1'b0; ign_rdy[3] = 1'b1;

        rst_n = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = SIZE_WORD;
        haddr = '0; hwdata = '0; hready_in = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        chk("rst_hresp", {31'b0, hresp}, 32'd0);
        rst_n = 1'b1;
        @(negedge pclk);

        // Transfers that must not start an APB access
        for (int i = 0; i < 4; i++) begin
            hsel = ign_hsel[i]; htrans = ign_trans[i]; hready_in = ign_rdy[i];
            haddr = 32'h70; hwrite = 1'b1;
            @(negedge pclk);
            @(negedge pclk);
            chk($sformatf("ignore%0d_psel", i), {31'b0, psel}, 32'd0);
            chk($sformatf("ignore%0d_hreadyout", i), {31'b0, hreadyout}, 32'd1);
            $display("[TB] ignore%0d hsel=%0d htrans=%0d hready_in=%0d psel=%0d", i,
                     ign_hsel[i], ign_trans[i], ign_rdy[i], psel);
        end
        hsel = 1'b0; htrans = HTRANS_IDLE; hready_in = 1'b1;
        @(negedge pclk);

        for (int i = 0; i < 12; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                     HTRANS_NONSEQ, vecs[i].wait_n, vecs[i].b2b, vecs[i].exp_waits,
                     vecs[i].exp_rdata, vecs[i].exp_strb);
            if (!vecs[i].wr) last_rd = vecs[i].exp_rdata;
        end

        // Reset asserted while the APB access is stalled
        @(negedge pclk);
        g_exp_addr = 32'h60; g_exp_write = 1'b0; g_exp_strb = 4'h0; g_wait = 20;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h60; hwrite = 1'b0; hsize = SIZE_WORD; hready_in = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hready_in = 1'b0;
        cnt = 0;
        while (!(psel && penable) && cnt < 10) begin
            @(negedge pclk);
            cnt++;
        end
        chk("midrst_reached_access", {31'b0, psel && penable}, 32'd1);
        @(negedge pclk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_psel", {31'b0, psel}, 32'd0);
        chk("midrst_penable", {31'b0, penable}, 32'd0);
        chk("midrst_hreadyout", {31'b0, hreadyout}, 32'd1);
        chk("midrst_hrdata", hrdata, 32'd0);
        chk("midrst_paddr", paddr, 32'd0);
        $display("[TB] midrst psel=%0d penable=%0d hreadyout=%0d", psel, penable, hreadyout);
        @(negedge pclk);
        rst_n = 1'b1; hready_in = 1'b1; g_wait = 1; last_rd = '0;
        @(negedge pclk);

        // Random transfers against the reference model
        for (int i = 0; i < 40; i++) begin
            bit          wr, b2b;
            logic [31:0] addr, data, exp_rd;
            logic [2:0]  sz;
            logic [1:0]  tr;
            int          wt, exp_w;
            wr   = 1'($urandom_range(0, 1));
            b2b  = 1'($urandom_range(0, 1));
            addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            data = $urandom;
            sz   = 3'($urandom_range(0, 2));
            tr   = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            wt   = int'($urandom_range(0, 3));
            exp_w = (wr ? 1 : 0) + 1 + (wt + 1);
            if (wr) begin
                model_mem[addr] = data;
                exp_rd = last_rd;
            end else begin
                exp_rd  = model_mem.exists(addr) ? model_mem[addr] : ~addr;
                last_rd = exp_rd;
            end
            run_xfer($sformatf("rnd%0d", i), wr, addr, data, sz, tr, wt, b2b, exp_w, exp_rd,
                     strb_rule(wr, addr, sz));
        end

        repeat (2) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
